// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the switch-bounce emulator.
package bounce_gen_pkg;

  // One-hot controller states.
  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    GAP    = 3'b010,
    SETTLE = 3'b100
  } state_t;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Galois LFSR that steps only when adv is high. A zero seed would
// lock the register, so it is swapped for the default seed.
module bounce_lfsr
  import bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED  = DEFAULT_SEED,
  parameter int          OUT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             adv,
  output logic [OUT_W-1:0] low
);

  localparam logic [15:0] INIT = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

  logic [15:0] lfsr;

  // Step the sequence once per load event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr <= INIT;
    end else if (adv) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Only the low bits feed the bounce-count and gap fields.
  assign low = lfsr[OUT_W-1:0];

endmodule

// File: rtl/bounce_gen.sv
// Switch-bounce emulator: turns a clean level into a glitch train of 2N+1
// edges with pseudo-random gaps, then holds off for SETTLE_CYC clocks.
// Optional macro BOUNCE_GEN_TICK_EN adds a tick port; gap counting then
// advances only on tick cycles (SETTLE stays clock-counted).
// Interface: level_in is a plain level (no handshake); a change is accepted
// only in IDLE or GAP; done is a one-cycle pulse when the output has settled.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED       = DEFAULT_SEED,
  parameter int          BCNT_W     = 3,
  parameter int          GAP_W      = 4,
  parameter int          SETTLE_CYC = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level_in,
`ifdef BOUNCE_GEN_TICK_EN
  input  logic tick,
`endif
  output logic sw_out,
  output logic busy,
  output logic done
);

  localparam int TW    = BCNT_W + 2;
  localparam int GW    = GAP_W + 1;
  localparam int SW    = $clog2(SETTLE_CYC + 1);
  localparam int OUT_W = (BCNT_W > GAP_W) ? BCNT_W : GAP_W;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  state_t          state, state_n;
  logic            target, target_n;
  logic            sw_n, done_n;
  logic [TW-1:0]   toggles_left, toggles_n;
  logic [GW-1:0]   gap_cnt, gap_n;
  logic [SW-1:0]   settle_cnt, settle_n;
  logic            adv, dec;
  logic [OUT_W-1:0] rnd;
  logic [TW-1:0]   two_n, retarget_load;
  logic [GW-1:0]   g_load;

  bounce_lfsr #(.SEED(SEED), .OUT_W(OUT_W)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (adv),
    .low     (rnd)
  );

`ifdef BOUNCE_GEN_TICK_EN
  assign dec = tick;
`else
  assign dec = 1'b1;
`endif

  // Random fields are taken from the LFSR value before it advances.
  assign two_n         = {1'b0, rnd[BCNT_W-1:0], 1'b0};
  assign g_load        = {1'b0, rnd[GAP_W-1:0]} + GW'(1);
  assign retarget_load = two_n + TW'(sw_out != level_in);
  assign busy          = (state != IDLE);

  // State, output and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      sw_out       <= 1'b0;
      target       <= 1'b0;
      done         <= 1'b0;
      toggles_left <= '0;
      gap_cnt      <= '0;
      settle_cnt   <= '0;
    end else begin
      state        <= state_n;
      sw_out       <= sw_n;
      target       <= target_n;
      done         <= done_n;
      toggles_left <= toggles_n;
      gap_cnt      <= gap_n;
      settle_cnt   <= settle_n;
    end
  end

  // Next-state logic: launch, bounce, retarget and settle.
  always_comb begin
    state_n   = state;
    sw_n      = sw_out;
    target_n  = target;
    toggles_n = toggles_left;
    gap_n     = gap_cnt;
    settle_n  = settle_cnt;
    done_n    = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        if (level_in != target) begin
          adv       = 1'b1;
          target_n  = level_in;
          sw_n      = level_in;
          toggles_n = two_n;
          gap_n     = g_load;
          settle_n  = '0;
          state_n   = (two_n == '0) ? SETTLE : GAP;
        end
      end
      GAP: begin
        if (level_in != target) begin
          // A retarget takes priority over a gap expiring in the same cycle.
          adv       = 1'b1;
          target_n  = level_in;
          toggles_n = retarget_load;
          gap_n     = g_load;
          if (retarget_load == '0) begin
            settle_n = '0;
            state_n  = SETTLE;
          end
        end else if (dec) begin
          if (gap_cnt == GW'(1)) begin
            adv       = 1'b1;
            sw_n      = ~sw_out;
            toggles_n = toggles_left - TW'(1);
            gap_n     = g_load;
            if (toggles_left == TW'(1)) begin
              settle_n = '0;
              state_n  = SETTLE;
            end
          end else begin
            gap_n = gap_cnt - GW'(1);
          end
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          settle_n = settle_cnt + SW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: an event-level model predicts every sw_out edge and
// done pulse; a monitor compares what the DUT shows against that queue.
module tb_bounce_gen;

  localparam int          SETTLE   = 32;
  localparam int unsigned SEED_VAL = 32'hACE1;
  localparam int unsigned MASK_VAL = 32'hB400;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic level_in = 1'b1;
  logic sw_out, busy, done;
`ifdef BOUNCE_GEN_TICK_EN
  logic tick = 1'b0;
  logic tick_hold = 1'b0;
  int   tick_div = 0;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int n_edges = 0;

  // Expected event: {kind(0=edge,1=done), value, cycle}
  logic [33:0] exp_q[$];

  bounce_gen dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .level_in (level_in),
`ifdef BOUNCE_GEN_TICK_EN
    .tick     (tick),
`endif
    .sw_out   (sw_out),
    .busy     (busy),
    .done     (done)
  );

  // Clock.
  always #5 clk = ~clk;

`ifdef BOUNCE_GEN_TICK_EN
  // Tick every 10 clocks unless held off.
  always begin
    @(posedge clk);
    #1;
    tick_div = (tick_div + 1) % 10;
    tick = (tick_div == 0) && !tick_hold;
  end
`endif

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_cyc = 0;
  int unsigned m_lfsr = SEED_VAL;
  bit m_rst_edge = 1'b1;
  bit m_target = 1'b0, m_sw = 1'b0, m_busy = 1'b0, m_train = 1'b0;
  int m_rem = 0, m_gap = 0, m_units = 0;
  int unsigned m_settle_end = 0;

  function automatic int unsigned step_lfsr(input int unsigned v);
    return (v >> 1) ^ (((v & 1) != 0) ? MASK_VAL : 0);
  endfunction

  function automatic logic [33:0] item(input bit kind, input bit val, input int unsigned cyc);
    return {kind, val, cyc};
  endfunction

  task automatic start_settle();
    m_train = 1'b0;
    m_settle_end = m_cyc + SETTLE;
  endtask

  // Model advances at each clock edge from the inputs sampled there.
  always @(posedge clk) begin
    bit unit;
    int n;
    m_cyc++;
    m_rst_edge = !reset_n;
`ifdef BOUNCE_GEN_TICK_EN
    unit = tick;
`else
    unit = 1'b1;
`endif
    if (!reset_n) begin
      m_lfsr = SEED_VAL; m_target = 0; m_sw = 0; m_busy = 0; m_train = 0;
      m_rem = 0; m_gap = 0; m_units = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (level_in != m_target) begin
        n = int'(m_lfsr % 8);
        m_gap = int'(m_lfsr % 16) + 1;
        m_lfsr = step_lfsr(m_lfsr);
        m_target = level_in;
        m_sw = level_in;
        exp_q.push_back(item(1'b0, m_sw, m_cyc));
        m_busy = 1'b1;
        m_rem = 2 * n;
        m_units = 0;
        if (m_rem == 0) start_settle(); else m_train = 1'b1;
      end
    end else if (m_train) begin
      if (level_in != m_target) begin
        n = int'(m_lfsr % 8);
        m_gap = int'(m_lfsr % 16) + 1;
        m_lfsr = step_lfsr(m_lfsr);
        m_rem = 2 * n + ((m_sw != level_in) ? 1 : 0);
        m_target = level_in;
        m_units = 0;
        if (m_rem == 0) start_settle();
      end else if (unit) begin
        m_units++;
        if (m_units == m_gap) begin
          m_sw = !m_sw;
          exp_q.push_back(item(1'b0, m_sw, m_cyc));
          m_rem--;
          m_gap = int'(m_lfsr % 16) + 1;
          m_lfsr = step_lfsr(m_lfsr);
          m_units = 0;
          if (m_rem == 0) start_settle();
        end
      end
    end else if (m_cyc == m_settle_end) begin
      m_busy = 1'b0;
      exp_q.push_back(item(1'b1, m_target, m_cyc));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit prev_sw = 1'b0;

  always @(negedge clk) begin
    logic [33:0] e;
    if (m_rst_edge) begin
      check("reset_sw_out", int'(sw_out), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
    end else begin
      check("busy", int'(busy), int'(m_busy));
      while (exp_q.size() > 0 && exp_q[0][31:0] < m_cyc) begin
        e = exp_q.pop_front();
        check(e[33] ? "missed_done_cycle" : "missed_edge_cycle", int'(m_cyc), int'(e[31:0]));
      end
      if (sw_out !== prev_sw) begin
        n_edges++;
        if (exp_q.size() == 0 || exp_q[0][33]) begin
          check("unexpected_edge", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("edge_cycle", int'(m_cyc), int'(e[31:0]));
          check("edge_value", int'(sw_out), int'(e[32]));
        end
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0 || !exp_q[0][33]) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", int'(m_cyc), int'(e[31:0]));
          check("done_sw_target", int'(sw_out), int'(e[32]));
        end
      end
    end
    prev_sw = sw_out;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step(1);
      if (!m_busy && level_in == m_target) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", int'(ok), 1);
  endtask

  task automatic wait_train_edges(input int k, input int bound);
    int base = n_edges;
    for (int i = 0; i < bound; i++) begin
      if (n_edges >= base + k || !m_train) break;
      step(1);
    end
  endtask

  initial begin
    // Reset held 3 cycles with level_in high, then the single rise.
    step(3);
    reset_n = 1'b1;
    wait_idle(2000);
    step(3);

    // Fall, then a rise that is retargeted back to 0 mid-gap.
    level_in = 1'b0;
    wait_idle(2000);
    level_in = 1'b1;
    step(1);
    wait_train_edges(3, 400);
    if (m_train) level_in = 1'b0;
    wait_idle(2000);

    // Change during settle is deferred until IDLE.
    level_in = 1'b1;
    for (int i = 0; i < 400 && !(m_busy && !m_train); i++) step(1);
    level_in = 1'b0;
    wait_idle(2000);

`ifdef BOUNCE_GEN_TICK_EN
    // Freeze the time base mid-train: output must hold and stay busy.
    level_in = 1'b1;
    step(1);
    begin
      bit held;
      tick_hold = 1'b1;
      step(2);
      held = sw_out;
      step(200);
      check("tick_hold_sw_frozen", int'(sw_out), int'(held));
      check("tick_hold_busy", int'(busy), 1);
      tick_hold = 1'b0;
    end
    wait_idle(4000);
`endif

    // Reset in the middle of a train abandons it.
    level_in = ~level_in;
    step($urandom_range(3, 20));
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    wait_idle(2000);

    // Soak: random level changes at random spacing.
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(1, 60));
      level_in = ~level_in;
    end
    wait_idle(4000);
    step(3);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
